beep_ctrl: RTL and testbench
============================

BEEP_CTRL -- requirements
Module: beep_ctrl

Interface
REQ-001 Parameter GAP, default 200, number of clk cycles the beeper is held cleared between consecutive beeps.
REQ-002 Parameter TMO, default 1500, maximum number of clk cycles spent in RUN before the beep is abandoned.
REQ-003 Port clk, input, 1, system clock (1 kHz); all state updates on the rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port req, input, 1, one-cycle strobe that enqueues n beeps.
REQ-006 Port n, input, 3, number of beeps to add on req; n=0 adds nothing.
REQ-007 Port over, input, 1, completion flag from the beeper, valid only while st=1.
REQ-008 Port st, output, 1, beeper enable; 0 holds the beeper cleared, 1 lets it run.
REQ-009 Port busy, output, 1, high in every state except IDLE.
REQ-010 Port pend, output, 4, beeps still queued, excluding the one in progress.
REQ-011 Port done, output, 1, one-cycle pulse when the queue drains.
REQ-012 Port ovf, output, 1, sticky flag set when a req is truncated by saturation.
REQ-013 Port tmo, output, 1, sticky flag set when a beep is abandoned by timeout.

Function
REQ-014 States: IDLE, CLR, RUN, GAPW; all outputs are registered.
REQ-015 Queue add: on req, pend <= min(15, pend + n - pop); saturation sets ovf.
REQ-016 Queue pop: pop=1 in the cycle IDLE->CLR or GAPW->CLR, which decrements pend by one. Simultaneous req and pop follow the REQ-015 formula.
REQ-017 IDLE transitions: st=0; if pend>0, go to CLR next cycle. A req arriving while pend=0 moves the block to CLR one cycle after pend becomes non-zero.
REQ-018 CLR: st=0 for exactly 2 cycles, then go to RUN.
REQ-019 RUN entry: st=1 and the timer restarts at 0.
REQ-020 RUN exit on completion: over=1 sampled -> GAPW.
REQ-021 RUN exit on timeout: timer reaching TMO-1 without over -> GAPW, tmo set.
REQ-022 RUN priority: over has priority over timeout in the same cycle.
REQ-023 GAPW: st=0 for exactly GAP cycles; then go to CLR (with pop) if pend>0, else go to IDLE.
REQ-024 done pulse: done=1 for one cycle coincident with the GAPW->IDLE transition.
REQ-025 over handling: over is ignored outside RUN.
REQ-026 Timer width: the timer is wide enough for max(GAP, TMO) and never wraps.
REQ-027 Clearing flags: ovf and tmo clear only on rst.

Reset
REQ-028 Asynchronous reset values: rst=1 immediately forces IDLE, st=0, busy=0, pend=0, done=0, ovf=0, tmo=0, timer=0.
REQ-029 Reset mid-beep: rst during RUN drops st to 0 asynchronously; the in-progress beep and the queue are discarded.
REQ-030 Reset release: after rst deasserts, the block stays in IDLE until pend>0.

Verification
REQ-031 Single beep: req with n=1; beeper model raises over 1000 cycles after st rises. Required: busy=1; st low for 2 cycles, then high; GAPW lasts 200 cycles; done pulses once; pend returns to 0.
REQ-032 Burst: req with n=3. Required: exactly 3 st high periods separated by 202 cycles low (GAP plus CLR); pend sequence 2,1,0; exactly one done.
REQ-033 Saturation: req with n=7 three times, back to back. Required: pend saturates at 15, counting the pop; ovf=1; exactly 16 beeps are produced.
REQ-034 Timeout: over never asserted. Required: st high for exactly 1500 cycles; tmo=1; sequencing continues.
REQ-035 Simultaneous events: req with n=2 in the same cycle as the GAPW->CLR pop while pend=1. Required: pend=2 next cycle.
REQ-036 Mid-run reset: assert rst 500 cycles into RUN. Required: st=0 in the same cycle; all outputs at reset values; no done.

Source files
------------

// File: rtl/beep_ctrl_if.sv
// Handshake bundle between a beep requester/beeper and beep_ctrl.
// The master side drives req/n/over; the slave side (the controller) drives the status outputs.
interface beep_ctrl_if;
    logic       req;
    logic [2:0] n;
    logic       over;
    logic       st;
    logic       busy;
    logic [3:0] pend;
    logic       done;
    logic       ovf;
    logic       tmo;

    modport master (output req, n, over, input st, busy, pend, done, ovf, tmo);
    modport slave  (input req, n, over, output st, busy, pend, done, ovf, tmo);
endinterface

// File: rtl/beep_ctrl.sv
// Beep sequencer: queues requested beeps and plays them one at a time.
// Each beep is a clear phase, a run phase ended by the beeper or a timeout, and a gap.
module beep_ctrl #(
    parameter int GAP = 200,
    parameter int TMO = 1500
) (
    input  logic        clk,
    input  logic        rst,
    beep_ctrl_if.slave  bus
);
    localparam int TMAX = (GAP > TMO) ? GAP : TMO;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, CLR, RUN, GAPW} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer;
    logic          pop;
    logic          to_hit;
    logic [4:0]    pend_sum;
    logic          sat;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        to_hit   = 1'b0;
        case (state)
            IDLE: if (bus.pend != 4'd0) begin
                state_nx = CLR;
                pop      = 1'b1;
            end
            CLR: if (timer == TW'(1)) state_nx = RUN;
            RUN: begin
                // Completion wins over a timeout landing on the same cycle.
                if (bus.over) begin
                    state_nx = GAPW;
                end else if (timer == TW'(TMO - 1)) begin
                    state_nx = GAPW;
                    to_hit   = 1'b1;
                end
            end
            GAPW: if (timer == TW'(GAP - 1)) begin
                if (bus.pend != 4'd0) begin
                    state_nx = CLR;
                    pop      = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A pop only happens with pend>0, so the difference never underflows.
    assign pend_sum = {1'b0, bus.pend} + (bus.req ? {2'b00, bus.n} : 5'd0) - {4'd0, pop};
    assign sat      = (pend_sum > 5'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            bus.st   <= 1'b0;
            bus.busy <= 1'b0;
            bus.pend <= 4'd0;
            bus.done <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.tmo  <= 1'b0;
        end else begin
            state    <= state_nx;
            // Timer restarts on every state change and is bounded by the exit compares.
            if (state_nx != state)  timer <= '0;
            else if (state != IDLE) timer <= timer + TW'(1);
            bus.st   <= (state_nx == RUN);
            bus.busy <= (state_nx != IDLE);
            bus.done <= (state == GAPW) && (state_nx == IDLE);
            bus.pend <= sat ? 4'd15 : pend_sum[3:0];
            if (sat)    bus.ovf <= 1'b1;
            if (to_hit) bus.tmo <= 1'b1;
        end
    end
endmodule

// File: tb/tb_beep_ctrl.sv
// Bench for beep_ctrl: directed steps plus randomized bursts, checked against beep
// lengths, gap lengths, pend traces and done counts derived from the timing rules.
module tb_beep_ctrl;
    localparam int GAP = 200;
    localparam int TMO = 1500;

    logic clk = 1'b0;
    logic rst;
    beep_ctrl_if bif();

    beep_ctrl #(.GAP(GAP), .TMO(TMO)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Beeper model controls.
    logic over_en = 1'b0;
    int   over_dly = 1000;

    // Monitor results (written only by the monitor process).
    int hi_q[$];
    int gap_q[$];
    int pend_q[$];
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Beeper: raises over for one cycle once st has been high over_dly cycles.
    initial begin
        int run_cnt;
        run_cnt = 0;
        bif.over = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.st === 1'b1 && over_en) begin
                run_cnt++;
                bif.over = (run_cnt == over_dly);
            end else begin
                run_cnt = 0;
                bif.over = 1'b0;
            end
        end
    end

    // Monitor: st high lengths, low gaps between beeps, pend changes, done pulses.
    initial begin
        logic       prev_st;
        logic [3:0] prev_pend;
        logic       in_gap;
        int         hi_cnt, lo_cnt;
        prev_st = 1'b0; prev_pend = 4'd0; in_gap = 1'b0; hi_cnt = 0; lo_cnt = 0;
        forever begin
            @(negedge clk);
            if (bif.st === 1'b1 && !prev_st) begin
                if (in_gap) gap_q.push_back(lo_cnt);
                hi_cnt = 1;
            end else if (bif.st === 1'b1) begin
                hi_cnt++;
            end else if (prev_st) begin
                hi_q.push_back(hi_cnt);
                lo_cnt = 1;
                in_gap = 1'b1;
            end else begin
                lo_cnt++;
            end
            if (bif.busy !== 1'b1) in_gap = 1'b0;
            if (bif.done === 1'b1) done_cnt++;
            if (bif.pend !== prev_pend) pend_q.push_back(int'(bif.pend));
            prev_st   = (bif.st === 1'b1);
            prev_pend = bif.pend;
        end
    end

    task automatic pulse_req(input logic [2:0] nv);
        @(negedge clk);
        bif.req = 1'b1;
        bif.n   = nv;
        @(negedge clk);
        bif.req = 1'b0;
        bif.n   = 3'd0;
    endtask

    task automatic wait_st(input logic lvl, input int budget, input string tag);
        int c = 0;
        while (bif.st !== lvl && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, bif.st, lvl);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c = 0;
        while (bif.busy !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(tag, bif.busy, 0);
    endtask

    // Expected shape of a finished burst: nb beeps of length len, GAP+2 low between them.
    task automatic chk_burst(input string tag, input int h0, input int g0, input int d0,
                             input int nb, input int len);
        chk({tag, " beeps"}, hi_q.size() - h0, nb);
        for (int i = 0; i < nb; i++)
            if (h0 + i < hi_q.size()) chk({tag, " len"}, hi_q[h0 + i], len);
        chk({tag, " gaps"}, gap_q.size() - g0, (nb > 0) ? nb - 1 : 0);
        for (int i = 0; i < nb - 1; i++)
            if (g0 + i < gap_q.size()) chk({tag, " gap"}, gap_q[g0 + i], GAP + 2);
        chk({tag, " done"}, done_cnt - d0, (nb > 0) ? 1 : 0);
        chk({tag, " pend"}, bif.pend, 0);
    endtask

    initial begin
        int h0, g0, d0, p0, c, nv, dv;
        rst = 1'b1;
        bif.req = 1'b0;
        bif.n   = 3'd0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst st", bif.st, 0);
        chk("rst busy", bif.busy, 0);
        chk("rst pend", bif.pend, 0);
        chk("rst done", bif.done, 0);
        chk("rst ovf", bif.ovf, 0);
        chk("rst tmo", bif.tmo, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle after rst", bif.busy, 0);

        // Single beep, over after 1000 cycles
        over_en = 1'b1; over_dly = 1000;
        h0 = hi_q.size(); g0 = gap_q.size(); d0 = done_cnt;
        pulse_req(3'd1);
        chk("single pend1", bif.pend, 1);
        chk("single busy0", bif.busy, 0);
        @(negedge clk);
        chk("single busy1", bif.busy, 1);
        chk("single clr st a", bif.st, 0);
        chk("single pop", bif.pend, 0);
        @(negedge clk);
        chk("single clr st b", bif.st, 0);
        @(negedge clk);
        chk("single run st", bif.st, 1);
        wait_st(1'b0, 1200, "single fall");
        c = 0;
        while (bif.busy === 1'b1 && c < 1000) begin
            c++;
            @(negedge clk);
        end
        chk("single gapw len", c, GAP);
        chk("single done hi", bif.done, 1);
        @(negedge clk);
        chk("single done lo", bif.done, 0);
        chk_burst("single", h0, g0, d0, 1, 1000);

        // Burst of three
        h0 = hi_q.size(); g0 = gap_q.size(); d0 = done_cnt; p0 = pend_q.size();
        pulse_req(3'd3);
        @(negedge clk);
        wait_idle(5000, "burst idle");
        @(negedge clk);
        chk_burst("burst", h0, g0, d0, 3, 1000);
        chk("burst pend trace", pend_q.size() - p0, 4);
        for (int i = 0; i < 4; i++)
            if (p0 + i < pend_q.size()) chk("burst pend seq", pend_q[p0 + i], 3 - i);

        // over and timeout on the same cycle: completion wins
        over_dly = TMO;
        h0 = hi_q.size(); g0 = gap_q.size(); d0 = done_cnt;
        pulse_req(3'd1);
        @(negedge clk);
        wait_idle(2500, "prio idle");
        @(negedge clk);
        chk_burst("prio", h0, g0, d0, 1, TMO);
        chk("prio tmo", bif.tmo, 0);

        // Saturation: three back-to-back n=7 requests
        over_dly = 20;
        h0 = hi_q.size(); g0 = gap_q.size(); d0 = done_cnt;
        @(negedge clk);
        bif.req = 1'b1; bif.n = 3'd7;
        @(negedge clk);
        chk("sat pend a", bif.pend, 7);
        @(negedge clk);
        chk("sat pend b", bif.pend, 13);
        chk("sat ovf b", bif.ovf, 0);
        @(negedge clk);
        chk("sat pend c", bif.pend, 15);
        chk("sat ovf c", bif.ovf, 1);
        bif.req = 1'b0; bif.n = 3'd0;
        wait_idle(8000, "sat idle");
        @(negedge clk);
        chk_burst("sat", h0, g0, d0, 16, 20);
        chk("sat ovf sticky", bif.ovf, 1);

        // Timeout: beeper never completes
        over_en = 1'b0;
        h0 = hi_q.size(); g0 = gap_q.size(); d0 = done_cnt;
        pulse_req(3'd2);
        chk("tmo pre", bif.tmo, 0);
        @(negedge clk);
        wait_idle(4000, "tmo idle");
        @(negedge clk);
        chk_burst("tmo", h0, g0, d0, 2, TMO);
        chk("tmo flag", bif.tmo, 1);

        // req coincident with the GAPW->CLR pop while pend=1
        over_en = 1'b1; over_dly = 20;
        h0 = hi_q.size(); g0 = gap_q.size(); d0 = done_cnt;
        pulse_req(3'd2);
        wait_st(1'b1, 10, "simul rise");
        wait_st(1'b0, 100, "simul fall");
        chk("simul pend1", bif.pend, 1);
        repeat (GAP - 1) @(negedge clk);
        chk("simul in gap", bif.st, 0);
        bif.req = 1'b1; bif.n = 3'd2;
        @(negedge clk);
        bif.req = 1'b0; bif.n = 3'd0;
        chk("simul pend2", bif.pend, 2);
        @(negedge clk);
        wait_idle(3000, "simul idle");
        @(negedge clk);
        chk_burst("simul", h0, g0, d0, 4, 20);

        // Reset 500 cycles into RUN
        over_dly = 1000;
        pulse_req(3'd3);
        wait_st(1'b1, 10, "mrst rise");
        repeat (500) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mrst st", bif.st, 0);
        chk("mrst busy", bif.busy, 0);
        chk("mrst pend", bif.pend, 0);
        chk("mrst done", bif.done, 0);
        chk("mrst ovf", bif.ovf, 0);
        chk("mrst tmo", bif.tmo, 0);
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mrst stays idle", bif.busy, 0);
        chk("mrst st idle", bif.st, 0);
        chk("mrst no done", done_cnt - d0, 0);

        // Randomized bursts
        for (int r = 0; r < 6; r++) begin
            nv = $urandom_range(0, 4);
            dv = $urandom_range(3, 80);
            over_dly = dv;
            h0 = hi_q.size(); g0 = gap_q.size(); d0 = done_cnt;
            pulse_req(3'(nv));
            @(negedge clk);
            wait_idle(nv * 300 + 50, "rand idle");
            @(negedge clk);
            chk_burst("rand", h0, g0, d0, nv, dv);
            chk("rand tmo", bif.tmo, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
